// File: rtl/tl_dcache_lookup_if.sv
// Purpose: TL-stage bundle: TL slot inputs, stall, line memory port and WB slot outputs.
// Latency: wires only; timing belongs to the producer/consumer of each field.
// Backpressure: stall_o from the slave tells the master to hold every tl_* field stable.
// Ports: slave modport is the cache lookup stage, master modport is the
//        upstream pipeline plus memory responder that drives it.
`timescale 1ns/1ps
interface tl_dcache_lookup_if #(
    parameter int LINE_WORDS = 4
);
    // TL slot from the EXE/TL latch
    logic                      tl_valid_i;
    logic [31:0]               tl_cache_addr_i;
    logic [4:0]                tl_write_addr_i;
    logic                      tl_int_write_enable_i;
    logic [31:0]               tl_store_data_i;
    logic                      tl_is_load_i;
    logic                      tl_is_store_i;
    logic [31:0]               tl_instruction_i;
    logic [31:0]               tl_pc_i;
    logic                      stall_o;

    // line-wide memory port
    logic                      mem_req_o;
    logic                      mem_we_o;
    logic [31:0]               mem_addr_o;
    logic [32*LINE_WORDS-1:0]  mem_wdata_o;
    logic                      mem_ack_i;
    logic [32*LINE_WORDS-1:0]  mem_rdata_i;

    // WB slot
    logic                      wb_valid_o;
    logic [4:0]                wb_write_addr_o;
    logic                      wb_int_write_enable_o;
    logic [31:0]               wb_data_o;
    logic [31:0]               wb_instruction_o;
    logic [31:0]               wb_pc_o;

    modport slave (
        input  tl_valid_i, tl_cache_addr_i, tl_write_addr_i, tl_int_write_enable_i,
               tl_store_data_i, tl_is_load_i, tl_is_store_i, tl_instruction_i, tl_pc_i,
               mem_ack_i, mem_rdata_i,
        output stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
               wb_valid_o, wb_write_addr_o, wb_int_write_enable_o, wb_data_o,
               wb_instruction_o, wb_pc_o
    );

    modport master (
        output tl_valid_i, tl_cache_addr_i, tl_write_addr_i, tl_int_write_enable_i,
               tl_store_data_i, tl_is_load_i, tl_is_store_i, tl_instruction_i, tl_pc_i,
               mem_ack_i, mem_rdata_i,
        input  stall_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
               wb_valid_o, wb_write_addr_o, wb_int_write_enable_o, wb_data_o,
               wb_instruction_o, wb_pc_o
    );
endinterface

// File: rtl/tl_dcache_lookup.sv
// Purpose: TL stage with a direct-mapped, write-back, word-granular data cache and writeback/refill FSM.
// Latency: 1 cycle TL->WB on a hit or non-memory op; misses add writeback/fill time plus one replay cycle.
// Backpressure: stall_o (combinational) holds upstream on a miss or while the FSM is busy; mem port waits for mem_ack_i.
// Ports: clk_i, rsn_i (synchronous, active-low) plus the slave side of
//        tl_dcache_lookup_if. Optional macro DCACHE_STATS_EN adds
//        hit_count_o / miss_count_o event counters.
`timescale 1ns/1ps
module tl_dcache_lookup #(
    parameter int LINES      = 4,
    parameter int LINE_WORDS = 4
) (
    input  logic               clk_i,
    input  logic               rsn_i,
`ifdef DCACHE_STATS_EN
    output logic [31:0]        hit_count_o,
    output logic [31:0]        miss_count_o,
`endif
    tl_dcache_lookup_if.slave  bus
);
    localparam int IDX_W  = $clog2(LINES);
    localparam int OFF_W  = $clog2(LINE_WORDS);
    localparam int TAG_W  = 32 - IDX_W - OFF_W - 2;
    localparam int LINE_W = 32 * LINE_WORDS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITEBACK,
        ST_FILL
    } state_t;

    state_t state_q, state_d;

    // cache storage: only valid/dirty need reset, tags/data are qualified by valid
    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] dirty_q;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES][LINE_WORDS];

    // registered memory request
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;

    // WB slot registers
    logic        wb_valid_q;
    logic [4:0]  wb_write_addr_q;
    logic        wb_int_we_q;
    logic [31:0] wb_data_q;
    logic [31:0] wb_instruction_q;
    logic [31:0] wb_pc_q;

    logic [OFF_W-1:0]  off;
    logic [IDX_W-1:0]  idx;
    logic [TAG_W-1:0]  req_tag;
    logic [31:0]       req_line_addr;
    logic [31:0]       victim_line_addr;
    logic [LINE_W-1:0] victim_line;
    logic              mem_op, hit, miss, stall;
    logic              load_acc, store_acc;
    logic              fill_done, wb_done, miss_start;
    logic              replay_q;
    logic              unused_addr_bits;

    assign off     = bus.tl_cache_addr_i[OFF_W+1:2];
    assign idx     = bus.tl_cache_addr_i[IDX_W+OFF_W+1:OFF_W+2];
    assign req_tag = bus.tl_cache_addr_i[31:IDX_W+OFF_W+2];
    assign unused_addr_bits = ^bus.tl_cache_addr_i[1:0];

    assign req_line_addr    = {req_tag, idx, {(OFF_W+2){1'b0}}};
    assign victim_line_addr = {tag_q[idx], idx, {(OFF_W+2){1'b0}}};

    always_comb begin
        victim_line = '0;
        for (int w = 0; w < LINE_WORDS; w++) begin
            victim_line[w*32 +: 32] = data_q[idx][w];
        end
    end

    assign mem_op = bus.tl_valid_i & (bus.tl_is_load_i | bus.tl_is_store_i);
    assign hit    = mem_op & valid_q[idx] & (tag_q[idx] == req_tag);
    assign miss   = mem_op & ~hit;
    assign stall  = miss | (state_q != ST_IDLE);

    // accepted accesses; hit already implies no miss, stall adds the FSM-busy case
    assign load_acc  = hit & ~stall & bus.tl_is_load_i;
    assign store_acc = hit & ~stall & bus.tl_is_store_i;

    // next-state and next memory-request values
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_done   = 1'b0;
        wb_done     = 1'b0;
        miss_start  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (miss) begin
                    miss_start = 1'b1;
                    mem_req_d  = 1'b1;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_d     = ST_WRITEBACK;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = victim_line_addr;
                        mem_wdata_d = victim_line;
                    end else begin
                        state_d    = ST_FILL;
                        mem_we_d   = 1'b0;
                        mem_addr_d = req_line_addr;
                    end
                end
            end
            ST_WRITEBACK: begin
                if (bus.mem_ack_i) begin
                    // chain straight into the fill without dropping req
                    wb_done    = 1'b1;
                    state_d    = ST_FILL;
                    mem_we_d   = 1'b0;
                    mem_addr_d = req_line_addr;
                end
            end
            ST_FILL: begin
                if (bus.mem_ack_i) begin
                    fill_done = 1'b1;
                    state_d   = ST_IDLE;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                mem_req_d = 1'b0;
                mem_we_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            valid_q     <= '0;
            dirty_q     <= '0;
            replay_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            // the cycle after a fill is the replay of the held instruction
            replay_q    <= fill_done;
            if (wb_done) begin
                dirty_q[idx] <= 1'b0;
            end
            if (fill_done) begin
                valid_q[idx] <= 1'b1;
                dirty_q[idx] <= 1'b0;
            end
            if (store_acc) begin
                dirty_q[idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rsn_i) begin
            if (fill_done) begin
                tag_q[idx] <= req_tag;
                for (int w = 0; w < LINE_WORDS; w++) begin
                    data_q[idx][w] <= bus.mem_rdata_i[w*32 +: 32];
                end
            end else if (store_acc) begin
                data_q[idx][off] <= bus.tl_store_data_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            wb_valid_q       <= 1'b0;
            wb_write_addr_q  <= '0;
            wb_int_we_q      <= 1'b0;
            wb_data_q        <= '0;
            wb_instruction_q <= '0;
            wb_pc_q          <= '0;
        end else if (stall) begin
            wb_valid_q <= 1'b0;
        end else begin
            wb_valid_q <= bus.tl_valid_i;
            if (bus.tl_valid_i) begin
                wb_write_addr_q  <= bus.tl_write_addr_i;
                wb_int_we_q      <= bus.tl_int_write_enable_i;
                wb_instruction_q <= bus.tl_instruction_i;
                wb_pc_q          <= bus.tl_pc_i;
                if (load_acc) begin
                    wb_data_q <= data_q[idx][off];
                end else if (store_acc) begin
                    wb_data_q <= bus.tl_store_data_i;
                end else begin
                    wb_data_q <= bus.tl_cache_addr_i;
                end
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q;
    logic [31:0] miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (!rsn_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if ((load_acc || store_acc) && !replay_q) begin
                hit_cnt_q <= hit_cnt_q + 32'd1;
            end
            if (miss_start) begin
                miss_cnt_q <= miss_cnt_q + 32'd1;
            end
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`endif

    assign bus.stall_o               = stall;
    assign bus.mem_req_o             = mem_req_q;
    assign bus.mem_we_o              = mem_we_q;
    assign bus.mem_addr_o            = mem_addr_q;
    assign bus.mem_wdata_o           = mem_wdata_q;
    assign bus.wb_valid_o            = wb_valid_q;
    assign bus.wb_write_addr_o       = wb_write_addr_q;
    assign bus.wb_int_write_enable_o = wb_int_we_q;
    assign bus.wb_data_o             = wb_data_q;
    assign bus.wb_instruction_o      = wb_instruction_q;
    assign bus.wb_pc_o               = wb_pc_q;

endmodule

// File: tb/tb_tl_dcache_lookup.sv
`timescale 1ns/1ps
module tb_tl_dcache_lookup;
    localparam int LW = 4;

    logic clk = 1'b0;
    logic rsn = 1'b0;
    always #5 clk = ~clk;

    tl_dcache_lookup_if #(.LINE_WORDS(LW)) bus ();

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    tl_dcache_lookup #(.LINES(4), .LINE_WORDS(LW)) dut (
        .clk_i        (clk),
        .rsn_i        (rsn),
`ifdef DCACHE_STATS_EN
        .hit_count_o  (hit_count),
        .miss_count_o (miss_count),
`endif
        .bus          (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [4:0]  waddr;
        logic        we;
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b required %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [LW*32-1:0] act, input logic [LW*32-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[15:0], 16'h0013};
    endfunction

    task automatic drive(input logic ld, input logic st, input logic [31:0] addr,
                         input logic [31:0] sdata, input logic [4:0] waddr,
                         input logic we, input logic [31:0] pc);
        bus.tl_valid_i            = 1'b1;
        bus.tl_is_load_i          = ld;
        bus.tl_is_store_i         = st;
        bus.tl_cache_addr_i       = addr;
        bus.tl_store_data_i       = sdata;
        bus.tl_write_addr_i       = waddr;
        bus.tl_int_write_enable_i = we;
        bus.tl_pc_i               = pc;
        bus.tl_instruction_i      = instr_of(pc);
        #1;
    endtask

    task automatic idle();
        bus.tl_valid_i    = 1'b0;
        bus.tl_is_load_i  = 1'b0;
        bus.tl_is_store_i = 1'b0;
    endtask

    task automatic expect_wb(input logic [31:0] data, input logic [4:0] waddr,
                             input logic we, input logic [31:0] pc);
        exp_t e;
        e.data  = data;
        e.waddr = waddr;
        e.we    = we;
        e.pc    = pc;
        e.instr = instr_of(pc);
        exp_q.push_back(e);
    endtask

    // memory responder: wait for a request, check it, hold the ack off for
    // `hold` cycles while checking stability, then pulse ack with rdata
    task automatic serve(input string name, input logic we, input logic [31:0] addr,
                         input logic [LW*32-1:0] rdata, input int hold,
                         input logic chk_wdata, input logic [LW*32-1:0] wdata);
        int n = 0;
        while (!bus.mem_req_o && n < 20) begin
            tick();
            n++;
        end
        chk1({name, "_req"}, bus.mem_req_o, 1'b1);
        chk1({name, "_we"}, bus.mem_we_o, we);
        chk32({name, "_addr"}, bus.mem_addr_o, addr);
        if (chk_wdata) chkw({name, "_wdata"}, bus.mem_wdata_o, wdata);
        for (int i = 0; i < hold; i++) begin
            tick();
            chk1({name, "_hold_req"}, bus.mem_req_o, 1'b1);
            chk32({name, "_hold_addr"}, bus.mem_addr_o, addr);
            chk1({name, "_hold_stall"}, bus.stall_o, 1'b1);
            chk1({name, "_hold_wbv"}, bus.wb_valid_o, 1'b0);
        end
        bus.mem_ack_i   = 1'b1;
        bus.mem_rdata_i = rdata;
        tick();
        bus.mem_ack_i   = 1'b0;
        bus.mem_rdata_i = '0;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (rsn && bus.wb_valid_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got wb_valid with pc %h, required no output", bus.wb_pc_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk32("wb_data", bus.wb_data_o, mon_e.data);
                chk32("wb_pc", bus.wb_pc_o, mon_e.pc);
                chk32("wb_instr", bus.wb_instruction_o, mon_e.instr);
                chk32("wb_waddr", 32'(bus.wb_write_addr_o), 32'(mon_e.waddr));
                chk1("wb_we", bus.wb_int_write_enable_o, mon_e.we);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog");
    end

    logic [LW*32-1:0] line0, line0_dirty, line1, line2;

    initial begin
        line0       = {32'h44444444, 32'h33333333, 32'h11111111, 32'hCAFEF00D};
        line0_dirty = {32'h44444444, 32'h33333333, 32'hDEADBEEF, 32'hCAFEF00D};
        line1       = {32'h77777777, 32'h66666666, 32'h55555555, 32'h0BADC0DE};
        line2       = {32'h99999999, 32'h88888888, 32'hAAAAAAAA, 32'h55AA55AA};

        idle();
        bus.tl_cache_addr_i       = '0;
        bus.tl_store_data_i       = '0;
        bus.tl_write_addr_i       = '0;
        bus.tl_int_write_enable_i = 1'b0;
        bus.tl_pc_i               = '0;
        bus.tl_instruction_i      = '0;
        bus.mem_ack_i             = 1'b0;
        bus.mem_rdata_i           = '0;
        rsn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_wb_valid", bus.wb_valid_o, 1'b0);
        chk1("rst_mem_req", bus.mem_req_o, 1'b0);
        chk1("rst_mem_we", bus.mem_we_o, 1'b0);
        chk32("rst_mem_addr", bus.mem_addr_o, 32'h0);
        chk32("rst_wb_data", bus.wb_data_o, 32'h0);
        chk1("rst_stall", bus.stall_o, 1'b0);
        rsn = 1'b1;
        tick();

        // non-memory op passes its ALU result through
        drive(1'b0, 1'b0, 32'h1234, 32'h0, 5'd5, 1'b1, 32'h100);
        chk1("alu_stall", bus.stall_o, 1'b0);
        expect_wb(32'h1234, 5'd5, 1'b1, 32'h100);
        tick();
        chk1("alu_stall_after", bus.stall_o, 1'b0);
        idle();
        tick();
        chk1("bubble_wb_valid", bus.wb_valid_o, 1'b0);

        // cold miss -> fill -> replay
        drive(1'b1, 1'b0, 32'h40, 32'h0, 5'd6, 1'b1, 32'h104);
        chk1("miss40_stall", bus.stall_o, 1'b1);
        expect_wb(32'hCAFEF00D, 5'd6, 1'b1, 32'h104);
        serve("fill40", 1'b0, 32'h40, line0, 0, 1'b0, '0);
        chk1("fill40_done_req", bus.mem_req_o, 1'b0);
        chk1("fill40_replay_stall", bus.stall_o, 1'b0);
        tick();
        idle();

        // store hit then load hit of the same word
        drive(1'b0, 1'b1, 32'h44, 32'hDEADBEEF, 5'd0, 1'b0, 32'h108);
        chk1("st44_stall", bus.stall_o, 1'b0);
        expect_wb(32'hDEADBEEF, 5'd0, 1'b0, 32'h108);
        tick();
        drive(1'b1, 1'b0, 32'h44, 32'h0, 5'd7, 1'b1, 32'h10C);
        chk1("ld44_stall", bus.stall_o, 1'b0);
        expect_wb(32'hDEADBEEF, 5'd7, 1'b1, 32'h10C);
        tick();
        idle();

        // conflict miss with dirty victim, fill ack held off 10 cycles
        drive(1'b1, 1'b0, 32'h80, 32'h0, 5'd8, 1'b1, 32'h110);
        chk1("miss80_stall", bus.stall_o, 1'b1);
        expect_wb(32'h0BADC0DE, 5'd8, 1'b1, 32'h110);
        serve("wb40", 1'b1, 32'h40, '0, 0, 1'b1, line0_dirty);
        serve("fill80", 1'b0, 32'h80, line1, 10, 1'b0, '0);
        chk1("fill80_done_req", bus.mem_req_o, 1'b0);
        chk1("fill80_replay_stall", bus.stall_o, 1'b0);
        tick();
        idle();

        // dirty the line again, start a writeback and reset in the middle of it
        drive(1'b0, 1'b1, 32'h84, 32'h12345678, 5'd0, 1'b0, 32'h114);
        expect_wb(32'h12345678, 5'd0, 1'b0, 32'h114);
        tick();
        drive(1'b1, 1'b0, 32'hC0, 32'h0, 5'd9, 1'b1, 32'h118);
        chk1("missC0_stall", bus.stall_o, 1'b1);
        tick();
        chk1("wbC0_req", bus.mem_req_o, 1'b1);
        chk1("wbC0_we", bus.mem_we_o, 1'b1);
        chk32("wbC0_addr", bus.mem_addr_o, 32'h80);
        chk32("wbC0_word1", bus.mem_wdata_o[63:32], 32'h12345678);
        rsn = 1'b0;
        idle();
        bus.mem_ack_i = 1'b1;
        tick();
        chk1("rstmid_req", bus.mem_req_o, 1'b0);
        chk1("rstmid_wb_valid", bus.wb_valid_o, 1'b0);
        chk1("rstmid_stall", bus.stall_o, 1'b0);
        rsn = 1'b1;
        bus.mem_ack_i = 1'b0;
        tick();
        bus.mem_ack_i = 1'b1;
        tick();
        bus.mem_ack_i = 1'b0;
        chk1("stray_ack_req", bus.mem_req_o, 1'b0);
        chk1("stray_ack_stall", bus.stall_o, 1'b0);

        // line was invalidated by reset: miss again, no writeback needed
        drive(1'b1, 1'b0, 32'h80, 32'h0, 5'd10, 1'b1, 32'h11C);
        chk1("reload80_stall", bus.stall_o, 1'b1);
        expect_wb(32'h55AA55AA, 5'd10, 1'b1, 32'h11C);
        serve("refill80", 1'b0, 32'h80, line2, 0, 1'b0, '0);
        chk1("refill80_replay_stall", bus.stall_o, 1'b0);
        tick();
        idle();
        tick();
        tick();

        chk32("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
